// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI-to-register-bus command sequencer.
// Holds the sequencer state encoding, the command-byte read flag position
// and the default parameter values used by spi_reg_ctrl.
package spi_reg_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CMD,
    WR_HI,
    WR_LO,
    WR_BUS,
    RD_BUS,
    RD_HI,
    RD_LO,
    DRAIN
  } state_t;

  // Bit of the command byte that selects a read (1) or a write (0).
  localparam int unsigned CMD_RD_BIT      = 7;
  localparam int unsigned DEF_ADDR_W      = 7;
  localparam int unsigned DEF_ACK_TIMEOUT = 255;

endpackage

// File: rtl/spi_reg_ctrl.sv
// Command sequencer between the SPI byte slave and the parameter register bus.
// Frames the MOSI byte stream into a command byte followed by 16-bit words,
// issues req/ack register writes or reads, auto-increments the address for
// bursts and schedules read-back bytes for MISO.
//
// Ports:
//   sys_clk, sys_rst            clock, synchronous active-high reset
//   spi_cs_active               chip select asserted
//   spi_rx_byte/spi_rx_valid    received byte and its one-cycle strobe
//   spi_tx_byte/spi_tx_load     next MISO byte and its one-cycle load strobe
//   reg_addr/reg_wdata          register bus address and write data
//   reg_we/reg_re               write/read request, held until ack or timeout
//   reg_ack/reg_rdata           bus completion and read data
//   busy                        sequencer not idle
//   err_overrun/err_timeout     sticky error flags, cleared on reset or CS rise
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              spi_cs_active,
  input  logic [7:0]        spi_rx_byte,
  input  logic              spi_rx_valid,
  output logic [7:0]        spi_tx_byte,
  output logic              spi_tx_load,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [15:0]       reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic              reg_ack,
  input  logic [15:0]       reg_rdata,
  output logic              busy,
  output logic              err_overrun,
  output logic              err_timeout
);

  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

  state_t        state, state_nxt;
  logic          cs_q;
  logic          cs_rise;
  logic [TW-1:0] tmo_cnt;
  logic          req_active;
  logic          tmo_hit;
  logic          bus_done;
  logic          drain_rd;
  logic [7:0]    rd_lo_q;
  logic          tx_load_nxt;

  assign cs_rise    = spi_cs_active & ~cs_q;
  assign req_active = (state == WR_BUS) || (state == RD_BUS) || (state == DRAIN);
  // Timeout fires on the ACK_TIMEOUT-th request cycle; an ack in that same
  // cycle still wins.
  assign tmo_hit    = req_active && !reg_ack && (tmo_cnt == TW'(ACK_TIMEOUT - 1));
  assign bus_done   = req_active && (reg_ack || tmo_hit);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  // A byte arriving together with CS deassertion is still consumed; the
  // following state then sees CS low and exits (via DRAIN if it requests).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (cs_rise) state_nxt = CMD;
      CMD: begin
        if (spi_rx_valid)        state_nxt = spi_rx_byte[CMD_RD_BIT] ? RD_BUS : WR_HI;
        else if (!spi_cs_active) state_nxt = IDLE;
      end
      WR_HI: begin
        if (spi_rx_valid)        state_nxt = WR_LO;
        else if (!spi_cs_active) state_nxt = IDLE;
      end
      WR_LO: begin
        if (spi_rx_valid)        state_nxt = WR_BUS;
        else if (!spi_cs_active) state_nxt = IDLE;
      end
      WR_BUS: begin
        if (bus_done)            state_nxt = spi_cs_active ? WR_HI : IDLE;
        else if (!spi_cs_active) state_nxt = DRAIN;
      end
      RD_BUS: begin
        if (bus_done)            state_nxt = spi_cs_active ? RD_HI : IDLE;
        else if (!spi_cs_active) state_nxt = DRAIN;
      end
      RD_HI: begin
        if (spi_rx_valid)        state_nxt = RD_LO;
        else if (!spi_cs_active) state_nxt = IDLE;
      end
      RD_LO: begin
        if (spi_rx_valid)        state_nxt = RD_BUS;
        else if (!spi_cs_active) state_nxt = IDLE;
      end
      DRAIN:  if (bus_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    reg_we      = 1'b0;
    reg_re      = 1'b0;
    busy        = (state != IDLE);
    case (state)
      WR_BUS: reg_we = 1'b1;
      RD_BUS: reg_re = 1'b1;
      DRAIN: begin
        reg_we = ~drain_rd;
        reg_re = drain_rd;
      end
      default: ;
    endcase
    tx_load_nxt = ((state == RD_BUS) && (state_nxt == RD_HI)) ||
                  ((state == RD_HI)  && (state_nxt == RD_LO));
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cs_q        <= 1'b0;
      tmo_cnt     <= '0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      rd_lo_q     <= '0;
      drain_rd    <= 1'b0;
      spi_tx_byte <= '0;
      spi_tx_load <= 1'b0;
      err_overrun <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      cs_q        <= spi_cs_active;
      spi_tx_load <= tx_load_nxt;
      // Runs across the RD_BUS/WR_BUS -> DRAIN hand-over: same request.
      tmo_cnt     <= (req_active && !bus_done) ? tmo_cnt + TW'(1) : '0;
      if (state != DRAIN) drain_rd <= (state == RD_BUS);

      case (state)
        CMD:    if (spi_rx_valid) reg_addr <= spi_rx_byte[ADDR_W-1:0];
        WR_HI:  if (spi_rx_valid) reg_wdata[15:8] <= spi_rx_byte;
        WR_LO:  if (spi_rx_valid) reg_wdata[7:0]  <= spi_rx_byte;
        WR_BUS: if (bus_done) reg_addr <= reg_addr + ADDR_W'(1);
        RD_BUS: begin
          if (bus_done) begin
            rd_lo_q     <= reg_ack ? reg_rdata[7:0]  : 8'h00;
            spi_tx_byte <= reg_ack ? reg_rdata[15:8] : 8'h00;
          end
        end
        RD_HI:  if (spi_rx_valid) spi_tx_byte <= rd_lo_q;
        RD_LO:  if (spi_rx_valid) reg_addr <= reg_addr + ADDR_W'(1);
        default: ;
      endcase

      if (cs_rise) begin
        err_overrun <= 1'b0;
        err_timeout <= 1'b0;
      end else begin
        if (spi_rx_valid && ((state == WR_BUS) || (state == RD_BUS))) err_overrun <= 1'b1;
        if (tmo_hit) err_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: a register-bus responder with a
// slave memory, a MISO byte monitor, and a transaction-level reference
// model that predicts bus cycles and read-back bytes from the command stream.
module tb_spi_reg_ctrl;

  localparam int unsigned ADDR_W      = 7;
  localparam int unsigned ACK_TIMEOUT = 8;
  localparam int          GAP         = 12;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic              spi_cs_active = 1'b0;
  logic [7:0]        spi_rx_byte = 8'h00;
  logic              spi_rx_valid = 1'b0;
  logic [7:0]        spi_tx_byte;
  logic              spi_tx_load;
  logic [ADDR_W-1:0] reg_addr;
  logic [15:0]       reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic              reg_ack;
  logic [15:0]       reg_rdata;
  logic              busy;
  logic              err_overrun;
  logic              err_timeout;

  spi_reg_ctrl #(.ADDR_W(ADDR_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .spi_cs_active (spi_cs_active),
    .spi_rx_byte   (spi_rx_byte),
    .spi_rx_valid  (spi_rx_valid),
    .spi_tx_byte   (spi_tx_byte),
    .spi_tx_load   (spi_tx_load),
    .reg_addr      (reg_addr),
    .reg_wdata     (reg_wdata),
    .reg_we        (reg_we),
    .reg_re        (reg_re),
    .reg_ack       (reg_ack),
    .reg_rdata     (reg_rdata),
    .busy          (busy),
    .err_overrun   (err_overrun),
    .err_timeout   (err_timeout)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    bit          we;
    logic [6:0]  addr;
    logic [15:0] wdata;
    int          cycles;
    bit          acked;
    bit          unstable;
  } ev_t;

  ev_t         act_q[$];
  ev_t         exp_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  exp_tx[$];
  logic [15:0] mem     [128];
  logic [15:0] ref_mem [128];
  logic [15:0] wbuf    [4];
  int          ack_delay = 2;
  int          skip_acks = 0;
  int          checks    = 0;
  int          failures  = 0;

  // Register bus responder: acks on the ack_delay-th request cycle unless the
  // request is marked to be starved; logs each request when it drops.
  int  held = 0;
  bit  pend = 0;
  ev_t cur;
  initial begin
    reg_ack   = 1'b0;
    reg_rdata = '0;
    forever begin
      @(negedge sys_clk);
      reg_ack = 1'b0;
      if (reg_we === 1'b1 || reg_re === 1'b1) begin
        if (!pend) begin
          pend         = 1;
          held         = 0;
          cur.we       = reg_we;
          cur.addr     = reg_addr;
          cur.wdata    = reg_wdata;
          cur.acked    = 0;
          cur.unstable = 0;
          cur.cycles   = 0;
        end else if (cur.we !== reg_we || cur.addr !== reg_addr ||
                     (reg_we && cur.wdata !== reg_wdata)) begin
          cur.unstable = 1;
        end
        held++;
        if (!cur.acked && skip_acks == 0 && held == ack_delay) begin
          reg_ack   = 1'b1;
          cur.acked = 1;
          if (reg_we) mem[reg_addr] = reg_wdata;
          else        reg_rdata     = mem[reg_addr];
        end
      end else if (pend) begin
        cur.cycles = held;
        act_q.push_back(cur);
        if (!cur.acked && skip_acks > 0) skip_acks--;
        pend = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge sys_clk);
      if (spi_tx_load === 1'b1) tx_q.push_back(spi_tx_byte);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    spi_rx_byte  = b;
    spi_rx_valid = 1'b1;
    @(negedge sys_clk);
    spi_rx_valid = 1'b0;
    tick(gap);
  endtask

  task automatic cs_on();
    spi_cs_active = 1'b1;
    tick(2);
  endtask

  task automatic cs_off();
    spi_cs_active = 1'b0;
    tick(4);
  endtask

  task automatic chk_reset_vals();
    chk("rst_tx_byte", spi_tx_byte, 8'h00);
    chk("rst_tx_load", spi_tx_load, 1'b0);
    chk("rst_addr",    reg_addr,    '0);
    chk("rst_wdata",   reg_wdata,   16'h0000);
    chk("rst_we",      reg_we,      1'b0);
    chk("rst_re",      reg_re,      1'b0);
    chk("rst_busy",    busy,        1'b0);
    chk("rst_ovr",     err_overrun, 1'b0);
    chk("rst_tmo",     err_timeout, 1'b0);
  endtask

  task automatic compare_all(input bit exp_tmo, input bit exp_ovr);
    chk("ev_count", act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      chk("ev_kind",   act_q[i].we,     exp_q[i].we);
      chk("ev_addr",   act_q[i].addr,   exp_q[i].addr);
      if (exp_q[i].we) chk("ev_wdata", act_q[i].wdata, exp_q[i].wdata);
      chk("ev_cycles", act_q[i].cycles, exp_q[i].cycles);
      chk("ev_acked",  act_q[i].acked,  exp_q[i].acked);
      chk("ev_stable", act_q[i].unstable, 1'b0);
    end
    chk("tx_count", tx_q.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++)
      chk("tx_byte", tx_q[i], exp_tx[i]);
    chk("end_busy", busy,        1'b0);
    chk("end_we",   reg_we,      1'b0);
    chk("end_re",   reg_re,      1'b0);
    chk("end_tmo",  err_timeout, exp_tmo);
    chk("end_ovr",  err_overrun, exp_ovr);
    act_q.delete();
    exp_q.delete();
    tx_q.delete();
    exp_tx.delete();
  endtask

  // One CS frame: command byte then n words. The first n_tmo bus requests
  // are starved and must time out. Reads prefetch one word past the burst.
  task automatic run_txn(input bit rd, input logic [6:0] a, input int n, input int n_tmo);
    ev_t         e;
    logic [6:0]  ad;
    logic [15:0] v;
    skip_acks = n_tmo;
    cs_on();
    send_byte({rd, a}, GAP);
    if (!rd) begin
      for (int i = 0; i < n; i++) begin
        ad       = 7'((int'(a) + i) % 128);
        e.we     = 1;
        e.addr   = ad;
        e.wdata  = wbuf[i];
        e.unstable = 0;
        if (i < n_tmo) begin
          e.cycles = ACK_TIMEOUT;
          e.acked  = 0;
        end else begin
          e.cycles    = ack_delay;
          e.acked     = 1;
          ref_mem[ad] = wbuf[i];
        end
        exp_q.push_back(e);
        send_byte(wbuf[i][15:8], GAP);
        send_byte(wbuf[i][7:0],  GAP);
      end
    end else begin
      for (int i = 0; i <= n; i++) begin
        ad         = 7'((int'(a) + i) % 128);
        e.we       = 0;
        e.addr     = ad;
        e.wdata    = '0;
        e.unstable = 0;
        if (i < n_tmo) begin
          e.cycles = ACK_TIMEOUT;
          e.acked  = 0;
          v        = 16'h0000;
        end else begin
          e.cycles = ack_delay;
          e.acked  = 1;
          v        = ref_mem[ad];
        end
        exp_q.push_back(e);
        exp_tx.push_back(v[15:8]);
        if (i < n) begin
          exp_tx.push_back(v[7:0]);
          send_byte(8'($urandom()), GAP);
          send_byte(8'($urandom()), GAP);
        end
      end
    end
    cs_off();
    compare_all(n_tmo > 0, 1'b0);
  endtask

  initial begin
    ev_t e;
    for (int i = 0; i < 128; i++) begin
      mem[i]     = 16'($urandom());
      ref_mem[i] = mem[i];
    end

    // Reset state
    tick(3);
    chk_reset_vals();
    sys_rst = 1'b0;
    tick(2);
    chk("idle_busy", busy, 1'b0);

    // Single write: 0x05, 0x12, 0x34 acked on the third cycle
    wbuf[0]   = 16'h1234;
    ack_delay = 3;
    run_txn(0, 7'h05, 1, 0);

    // Single read of 0xBEEF at address 5, then prefetch at 6
    mem[5]     = 16'hBEEF;
    ref_mem[5] = 16'hBEEF;
    ack_delay  = 2;
    run_txn(1, 7'h05, 1, 0);

    // Burst write across the address wrap: 127 then 0
    wbuf[0]   = 16'($urandom());
    wbuf[1]   = 16'($urandom());
    ack_delay = 1;
    run_txn(0, 7'h7F, 2, 0);

    // First word starved until timeout, second word lands at address+1
    wbuf[0]   = 16'($urandom());
    wbuf[1]   = 16'($urandom());
    ack_delay = 2;
    run_txn(0, 7'h30, 2, 1);

    // New frame must clear the sticky timeout flag
    wbuf[0]   = 16'($urandom());
    ack_delay = 4;
    run_txn(0, 7'h31, 1, 0);

    // Extra byte while the write is on the bus is dropped and flagged
    ack_delay = 6;
    skip_acks = 0;
    wbuf[0]   = 16'($urandom());
    wbuf[1]   = 16'($urandom());
    cs_on();
    send_byte(8'h10, GAP);
    send_byte(wbuf[0][15:8], GAP);
    send_byte(wbuf[0][7:0], 1);
    send_byte(8'hAA, GAP);
    send_byte(wbuf[1][15:8], GAP);
    send_byte(wbuf[1][7:0], GAP);
    cs_off();
    e = '{we: 1, addr: 7'h10, wdata: wbuf[0], cycles: 6, acked: 1, unstable: 0};
    exp_q.push_back(e);
    ref_mem[7'h10] = wbuf[0];
    e = '{we: 1, addr: 7'h11, wdata: wbuf[1], cycles: 6, acked: 1, unstable: 0};
    exp_q.push_back(e);
    ref_mem[7'h11] = wbuf[1];
    compare_all(1'b0, 1'b1);

    // Reset alone clears the sticky overrun flag
    sys_rst = 1'b1;
    tick(1);
    chk("rst_clears_ovr", err_overrun, 1'b0);
    sys_rst = 1'b0;
    tick(2);

    // Reset while waiting for the low data byte
    cs_on();
    send_byte(8'h20, GAP);
    send_byte(8'h55, GAP);
    chk("pre_rst_addr", reg_addr, 7'h20);
    sys_rst       = 1'b1;
    spi_cs_active = 1'b0;
    tick(1);
    chk_reset_vals();
    sys_rst = 1'b0;
    tick(2);
    wbuf[0]   = 16'($urandom());
    ack_delay = 3;
    run_txn(0, 7'h20, 1, 0);

    // CS drops with a read pending: DRAIN keeps the request until ack
    ack_delay = 6;
    skip_acks = 0;
    cs_on();
    send_byte(8'h85, 2);
    spi_cs_active = 1'b0;
    tick(1);
    chk("drain_busy", busy, 1'b1);
    chk("drain_re",   reg_re, 1'b1);
    tick(6);
    e = '{we: 0, addr: 7'h05, wdata: '0, cycles: 6, acked: 1, unstable: 0};
    exp_q.push_back(e);
    compare_all(1'b0, 1'b0);

    // Randomized frames
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 4; i++) wbuf[i] = 16'($urandom());
      ack_delay = $urandom_range(1, 5);
      run_txn(1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)),
              $urandom_range(1, 3), ($urandom_range(0, 3) == 0) ? 1 : 0);
    end

    // Read that times out returns zero bytes, next read proceeds
    ack_delay = 2;
    run_txn(1, 7'h40, 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
